tl_slave_beh: RTL and testbench
===============================

Name: tl_slave_beh

Overview:
- Behavioral TileLink responder (manager end), single-beat TL-UL/TL-UH subset.
- Backed by a local word-addressed memory.
- Sits on the far side of a crossbar from the behavioral tile masters in cosim, standing in for a memory-mapped device or scratchpad.
- Accepts Get/PutFullData/PutPartialData on channel A and returns AccessAckData/AccessAck on channel D after a programmable latency.

Parameters:
- SRC_SIZE, 2, width of a/d source field
- SINK_SIZE, 2, width of d sink field
- BUS_SIZE, 8, data bus bytes (data width = 8*BUS_SIZE, mask width = BUS_SIZE)
- ADR_WIDTH, 32, address width
- BASE_ADDR, 32'h6000_0000, first byte address served
- DEPTH, 1024, number of BUS_SIZE-byte words in memory
- RESP_LATENCY, 1, cycles from A fire to d_valid assertion (>=1)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- tl_a_valid  in  1  A request valid
- tl_a_ready  out  1  A ready
- tl_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- tl_a_bits_param  in  3  ignored
- tl_a_bits_size  in  4  log2 bytes
- tl_a_bits_source  in  SRC_SIZE  request tag
- tl_a_bits_address  in  ADR_WIDTH  byte address
- tl_a_bits_mask  in  BUS_SIZE  byte enables
- tl_a_bits_data  in  8*BUS_SIZE  write data
- tl_a_bits_corrupt  in  1  write data corrupt
- tl_d_valid  out  1  response valid
- tl_d_ready  in  1  response ready
- tl_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- tl_d_bits_param  out  2  always 0
- tl_d_bits_size  out  4  echo of a size
- tl_d_bits_source  out  SRC_SIZE  echo of a source
- tl_d_bits_sink  out  SINK_SIZE  always 0
- tl_d_bits_denied  out  1  request rejected
- tl_d_bits_data  out  8*BUS_SIZE  read data
- tl_d_bits_corrupt  out  1  data invalid
- req_count  out  32  accepted A requests since reset
- err_count  out  32  denied requests since reset

Behaviour:
- Reset (async assert, sync release): state=IDLE; tl_a_ready=0 while reset_n low, 1 on first cycle after release. tl_d_valid=0. All d_bits=0. req_count=0, err_count=0. Memory contents not reset.
- Reset mid-operation: in-flight request dropped, no D response, pending write already committed stays committed.
- FSM IDLE -> WAIT -> RESP -> IDLE; one outstanding request only.
- IDLE: a_ready=1. A fire = a_valid&a_ready. On fire: latch opcode, size, source; evaluate legality; perform write or read at that edge; req_count++; load latency counter with RESP_LATENCY-1; go to WAIT, or straight to RESP if RESP_LATENCY==1.
- WAIT: a_ready=0; counter decrements each cycle; at 0 go to RESP.
- RESP: d_valid=1, d_bits stable until d_ready. On d fire go to IDLE; a_ready returns 1 the following cycle (no same-cycle A accept).
- Latency: d_valid first asserts exactly RESP_LATENCY cycles after the A-fire edge.
- Legality, denied=1 if any of:
  - opcode not in {0,1,4}
  - size > log2(BUS_SIZE)
  - address not aligned to 2^size
  - address < BASE_ADDR or address >= BASE_ADDR + DEPTH*BUS_SIZE
- Word index = (address - BASE_ADDR) >> log2(BUS_SIZE).
- Put, legal, a_corrupt=0: write bytes where mask bit=1; return AccessAck, denied=0, data=0, corrupt=0.
- Put with a_corrupt=1: write suppressed; AccessAck, denied=0.
- Get, legal: data = full word read at fire edge (mask ignored); AccessAckData, corrupt=0.
- Denied: no write; opcode = AccessAckData for Get or illegal opcode, AccessAck for Puts; data=0; corrupt=1 when opcode=AccessAckData; err_count++ at fire.
- Counters wrap at 2^32 - 1 -> 0.
- d_valid never drops without d_ready; a_valid while busy is simply not accepted.

Test Plan:
- Reset release, PutFull addr 0x6000_0008 size 3 mask 0xFF data 0x1122334455667788 src 2 -> d_valid 1 cycle later, opcode 0, source 2, size 3, denied 0; req_count=1.
- Get addr 0x6000_0008 size 3 -> opcode 1, data 0x1122334455667788, corrupt 0. Then PutPartial mask 0x0F data 0xAAAAAAAAAAAAAAAA, Get -> data 0x11223344AAAAAAAA.
- RESP_LATENCY=4, hold d_ready=0 for 3 cycles -> d_valid rises 4 cycles after A fire, bits stable; a_ready=0 throughout; a_ready=1 one cycle after d fire.
- Get addr 0x6000_2000 (DEPTH=1024, out of range), Get addr 0x6000_0004 size 3 (misaligned), opcode 2 -> each denied=1, corrupt=1, data 0; err_count=3.
- PutFull with a_corrupt=1 to word 5, then Get word 5 -> AccessAck, denied 0; Get returns prior contents.
- Assert reset_n low during WAIT -> d_valid=0 immediately; after release a_ready=1, no stale response, req_count=0.

Source files
------------

// File: rtl/tl_slave_beh.sv
// -----------------------------------------------------------------------------
// tl_slave_beh
// Behavioural TileLink manager (single-beat TL-UL/TL-UH subset) backed by a
// local word-addressed memory. Accepts Get / PutFullData / PutPartialData on
// channel A and answers with AccessAckData / AccessAck on channel D after a
// fixed, parameterised latency. Only one request is outstanding at a time.
//
// Ports
//   clock, reset_n           : clock (rising edge), async active-low reset
//   tl_a_*                   : channel A request (valid/ready + bits)
//   tl_d_*                   : channel D response (valid/ready + bits)
//   req_count                : A requests accepted since reset (wraps)
//   err_count                : denied requests since reset (wraps)
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request, a_ready=1
// WAIT  | request taken, latency counter running down
// RESP  | d_valid=1, holding response bits until d_ready
// -----------------------------------------------------------------------------
module tl_slave_beh #(
    parameter int                      SRC_SIZE     = 2,
    parameter int                      SINK_SIZE    = 2,
    parameter int                      BUS_SIZE     = 8,
    parameter int                      ADR_WIDTH    = 32,
    parameter logic [ADR_WIDTH-1:0]    BASE_ADDR    = 32'h6000_0000,
    parameter int                      DEPTH        = 1024,
    parameter int                      RESP_LATENCY = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,

    input  logic                       tl_a_valid,
    output logic                       tl_a_ready,
    input  logic [2:0]                 tl_a_bits_opcode,
    input  logic [2:0]                 tl_a_bits_param,
    input  logic [3:0]                 tl_a_bits_size,
    input  logic [SRC_SIZE-1:0]        tl_a_bits_source,
    input  logic [ADR_WIDTH-1:0]       tl_a_bits_address,
    input  logic [BUS_SIZE-1:0]        tl_a_bits_mask,
    input  logic [8*BUS_SIZE-1:0]      tl_a_bits_data,
    input  logic                       tl_a_bits_corrupt,

    output logic                       tl_d_valid,
    input  logic                       tl_d_ready,
    output logic [2:0]                 tl_d_bits_opcode,
    output logic [1:0]                 tl_d_bits_param,
    output logic [3:0]                 tl_d_bits_size,
    output logic [SRC_SIZE-1:0]        tl_d_bits_source,
    output logic [SINK_SIZE-1:0]       tl_d_bits_sink,
    output logic                       tl_d_bits_denied,
    output logic [8*BUS_SIZE-1:0]      tl_d_bits_data,
    output logic                       tl_d_bits_corrupt,

    output logic [31:0]                req_count,
    output logic [31:0]                err_count
);

    localparam int DATA_W  = 8 * BUS_SIZE;
    localparam int LOG_BUS = $clog2(BUS_SIZE);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W   = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

    localparam logic [ADR_WIDTH-1:0] SPAN = ADR_WIDTH'(DEPTH * BUS_SIZE);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [LAT_W-1:0]       r_lat_cnt;

    logic [DATA_W-1:0]      r_mem [DEPTH];

    logic [2:0]             r_d_opcode;
    logic [3:0]             r_d_size;
    logic [SRC_SIZE-1:0]    r_d_source;
    logic                   r_d_denied;
    logic [DATA_W-1:0]      r_d_data;
    logic                   r_d_corrupt;
    logic [31:0]            r_req_count;
    logic [31:0]            r_err_count;

    logic                   w_a_fire;
    logic                   w_is_get;
    logic                   w_is_put;
    logic                   w_size_ok;
    logic                   w_in_range;
    logic                   w_aligned;
    logic                   w_param_unused;
    logic                   w_denied;
    logic                   w_wr_en;
    logic [ADR_WIDTH-1:0]   w_offset;
    logic [ADR_WIDTH-1:0]   w_align_mask;
    logic [IDX_W-1:0]       w_idx;
    logic [2:0]             w_resp_op;
    logic [DATA_W-1:0]      w_rd_data;

    // ------------------------------------------------------------------
    // Request decode and legality
    // ------------------------------------------------------------------
    assign tl_a_ready   = (r_state == ST_IDLE) && reset_n;
    assign w_a_fire     = tl_a_valid && tl_a_ready;

    assign w_is_get     = (tl_a_bits_opcode == OP_GET);
    assign w_is_put     = (tl_a_bits_opcode == OP_PUT_FULL) ||
                          (tl_a_bits_opcode == OP_PUT_PARTIAL);

    assign w_size_ok    = (tl_a_bits_size <= 4'(LOG_BUS));
    assign w_align_mask = (ADR_WIDTH'(1) << tl_a_bits_size) - ADR_WIDTH'(1);
    assign w_aligned    = ((tl_a_bits_address & w_align_mask) == '0);

    // Offset is only meaningful when the address is at or above the base;
    // the first term guards against the subtraction wrapping.
    assign w_offset     = tl_a_bits_address - BASE_ADDR;
    assign w_in_range   = (tl_a_bits_address >= BASE_ADDR) && (w_offset < SPAN);
    assign w_idx        = w_offset[LOG_BUS +: IDX_W];

    // a_param has no meaning for Get/Put; it is folded in as a constant-zero
    // term so the input is visibly consumed.
    assign w_param_unused = 1'b0 & (^tl_a_bits_param);

    assign w_denied     = !(w_is_get || w_is_put) || !w_size_ok ||
                          !w_aligned || !w_in_range || w_param_unused;

    assign w_resp_op    = w_is_put ? OP_ACK : OP_ACK_DATA;
    assign w_wr_en      = w_a_fire && !w_denied && w_is_put && !tl_a_bits_corrupt;
    assign w_rd_data    = r_mem[w_idx];

    // ------------------------------------------------------------------
    // Backing memory (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int b = 0; b < BUS_SIZE; b++) begin
                if (tl_a_bits_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= tl_a_bits_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_a_fire) begin
                    w_state_nxt = (RESP_LATENCY <= 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Leaving on a count of 1 makes d_valid rise exactly
                // RESP_LATENCY edges after the A fire edge.
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tl_d_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= '0;
        end else if (w_a_fire) begin
            r_lat_cnt <= LAT_W'(RESP_LATENCY - 1);
        end else if (r_state == ST_WAIT) begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response capture and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_opcode  <= '0;
            r_d_size    <= '0;
            r_d_source  <= '0;
            r_d_denied  <= 1'b0;
            r_d_data    <= '0;
            r_d_corrupt <= 1'b0;
            r_req_count <= '0;
            r_err_count <= '0;
        end else if (w_a_fire) begin
            r_d_opcode  <= w_resp_op;
            r_d_size    <= tl_a_bits_size;
            r_d_source  <= tl_a_bits_source;
            r_d_denied  <= w_denied;
            r_d_data    <= (w_is_get && !w_denied) ? w_rd_data : '0;
            r_d_corrupt <= w_denied && (w_resp_op == OP_ACK_DATA);
            r_req_count <= r_req_count + 32'd1;
            if (w_denied) begin
                r_err_count <= r_err_count + 32'd1;
            end
        end
    end

    assign tl_d_valid        = (r_state == ST_RESP);
    assign tl_d_bits_opcode  = r_d_opcode;
    assign tl_d_bits_param   = '0;
    assign tl_d_bits_size    = r_d_size;
    assign tl_d_bits_source  = r_d_source;
    assign tl_d_bits_sink    = '0;
    assign tl_d_bits_denied  = r_d_denied;
    assign tl_d_bits_data    = r_d_data;
    assign tl_d_bits_corrupt = r_d_corrupt;
    assign req_count         = r_req_count;
    assign err_count         = r_err_count;

endmodule

// File: tb/tb_tl_slave_beh.sv
// Bench for tl_slave_beh: one instance at latency 1 for functional traffic,
// one at latency 4 for timing and reset-in-flight scenarios.
module tb_tl_slave_beh;

    localparam logic [31:0] BASE = 32'h6000_0000;
    localparam longint      SPAN = 1024 * 8;

    logic        clock = 1'b0;
    logic        reset_n;
    always #5 clock = ~clock;

    // shared A bits
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;

    // latency-1 instance
    logic        a_valid, a_ready, d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param, d_source, d_sink;
    logic [3:0]  d_size;
    logic        d_denied, d_corrupt;
    logic [63:0] d_data;
    logic [31:0] req_count, err_count;

    // latency-4 instance
    logic        a_valid4, a_ready4, d_valid4, d_ready4;
    logic [2:0]  d_opcode4;
    logic [1:0]  d_param4, d_source4, d_sink4;
    logic [3:0]  d_size4;
    logic        d_denied4, d_corrupt4;
    logic [63:0] d_data4;
    logic [31:0] req_count4, err_count4;

    tl_slave_beh dut (
        .clock(clock), .reset_n(reset_n),
        .tl_a_valid(a_valid), .tl_a_ready(a_ready),
        .tl_a_bits_opcode(a_opcode), .tl_a_bits_param(a_param),
        .tl_a_bits_size(a_size), .tl_a_bits_source(a_source),
        .tl_a_bits_address(a_address), .tl_a_bits_mask(a_mask),
        .tl_a_bits_data(a_data), .tl_a_bits_corrupt(a_corrupt),
        .tl_d_valid(d_valid), .tl_d_ready(d_ready),
        .tl_d_bits_opcode(d_opcode), .tl_d_bits_param(d_param),
        .tl_d_bits_size(d_size), .tl_d_bits_source(d_source),
        .tl_d_bits_sink(d_sink), .tl_d_bits_denied(d_denied),
        .tl_d_bits_data(d_data), .tl_d_bits_corrupt(d_corrupt),
        .req_count(req_count), .err_count(err_count)
    );

    tl_slave_beh #(.RESP_LATENCY(4)) dut4 (
        .clock(clock), .reset_n(reset_n),
        .tl_a_valid(a_valid4), .tl_a_ready(a_ready4),
        .tl_a_bits_opcode(a_opcode), .tl_a_bits_param(a_param),
        .tl_a_bits_size(a_size), .tl_a_bits_source(a_source),
        .tl_a_bits_address(a_address), .tl_a_bits_mask(a_mask),
        .tl_a_bits_data(a_data), .tl_a_bits_corrupt(a_corrupt),
        .tl_d_valid(d_valid4), .tl_d_ready(d_ready4),
        .tl_d_bits_opcode(d_opcode4), .tl_d_bits_param(d_param4),
        .tl_d_bits_size(d_size4), .tl_d_bits_source(d_source4),
        .tl_d_bits_sink(d_sink4), .tl_d_bits_denied(d_denied4),
        .tl_d_bits_data(d_data4), .tl_d_bits_corrupt(d_corrupt4),
        .req_count(req_count4), .err_count(err_count4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_req  = 0;
    int exp_err  = 0;
    logic [63:0] mdl [8];   // reference contents of words 0..7

    // Drives one request into the latency-1 instance and returns what D showed.
    task automatic xfer(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                        input logic [31:0] adr, input logic [7:0] msk, input logic [63:0] dat,
                        input logic cor, input int hold,
                        output logic ok, output int lat, output logic stable,
                        output logic [2:0] o_op, output logic [3:0] o_sz, output logic [1:0] o_src,
                        output logic o_den, output logic [63:0] o_dat, output logic o_cor);
        int waitc;
        ok = 1'b0; lat = 0; stable = 1'b1;
        o_op = '0; o_sz = '0; o_src = '0; o_den = 1'b0; o_dat = '0; o_cor = 1'b0;
        @(negedge clock);
        a_opcode = op; a_size = sz; a_source = src; a_address = adr;
        a_mask = msk; a_data = dat; a_corrupt = cor; a_param = 3'($urandom_range(0, 7));
        a_valid = 1'b1;
        waitc = 0;
        while (!a_ready && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        if (a_ready) begin
            @(posedge clock);
            @(negedge clock);
            a_valid = 1'b0;
            lat = 1;
            while (!d_valid && lat < 20) begin
                @(negedge clock);
                lat++;
            end
            if (d_valid) begin
                ok = 1'b1;
                o_op = d_opcode; o_sz = d_size; o_src = d_source;
                o_den = d_denied; o_dat = d_data; o_cor = d_corrupt;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clock);
                    if (d_valid !== 1'b1 || d_opcode !== o_op || d_data !== o_dat ||
                        d_denied !== o_den || d_corrupt !== o_cor || d_source !== o_src)
                        stable = 1'b0;
                end
                d_ready = 1'b1;
                @(posedge clock);
                @(negedge clock);
                d_ready = 1'b0;
            end
        end else begin
            a_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_valid = 0; a_valid4 = 0; d_ready = 0; d_ready4 = 0;
        a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
        a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (a_ready !== 1'b0 || a_ready4 !== 1'b0) begin
            n_errors++; $display("FAIL reset_a_ready: got %b/%b want 0", a_ready, a_ready4);
        end
        n_checks++;
        if (d_valid !== 1'b0 || d_opcode !== 3'd0 || d_data !== 64'd0 || d_denied !== 1'b0) begin
            n_errors++; $display("FAIL reset_d: valid=%b op=%0d data=%h den=%b want zeros",
                                 d_valid, d_opcode, d_data, d_denied);
        end
        n_checks++;
        if (req_count !== 32'd0 || err_count !== 32'd0) begin
            n_errors++; $display("FAIL reset_counts: req=%0d err=%0d want 0", req_count, err_count);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_release_a_ready: got %b want 1", a_ready);
        end
    endtask

    task automatic test_put_get();
        logic ok, st, den, cor;
        int lat;
        logic [2:0] op; logic [3:0] sz; logic [1:0] src; logic [63:0] dat;
        xfer(3'd0, 4'd3, 2'd2, BASE + 32'h8, 8'hFF, 64'h1122334455667788, 1'b0, 0,
             ok, lat, st, op, sz, src, den, dat, cor);
        exp_req++;
        n_checks++;
        if (!ok || lat != 1) begin
            n_errors++; $display("FAIL putfull_latency: ok=%b lat=%0d want lat 1", ok, lat);
        end
        n_checks++;
        if (op !== 3'd0 || src !== 2'd2 || sz !== 4'd3 || den !== 1'b0 || cor !== 1'b0) begin
            n_errors++; $display("FAIL putfull_resp: op=%0d src=%0d sz=%0d den=%b cor=%b want 0/2/3/0/0",
                                 op, src, sz, den, cor);
        end
        n_checks++;
        if (req_count !== 32'd1) begin
            n_errors++; $display("FAIL putfull_req_count: got %0d want 1", req_count);
        end
        xfer(3'd4, 4'd3, 2'd1, BASE + 32'h8, 8'h00, 64'd0, 1'b0, 0,
             ok, lat, st, op, sz, src, den, dat, cor);
        exp_req++;
        n_checks++;
        if (!ok || op !== 3'd1 || dat !== 64'h1122334455667788 || cor !== 1'b0 || den !== 1'b0) begin
            n_errors++; $display("FAIL get_full: ok=%b op=%0d data=%h cor=%b want 1 1122334455667788 0",
                                 ok, op, dat, cor);
        end
        xfer(3'd1, 4'd3, 2'd0, BASE + 32'h8, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 0,
             ok, lat, st, op, sz, src, den, dat, cor);
        exp_req++;
        xfer(3'd4, 4'd3, 2'd3, BASE + 32'h8, 8'hFF, 64'd0, 1'b0, 0,
             ok, lat, st, op, sz, src, den, dat, cor);
        exp_req++;
        n_checks++;
        if (!ok || dat !== 64'h11223344AAAAAAAA || src !== 2'd3) begin
            n_errors++; $display("FAIL get_partial: data=%h src=%0d want 11223344aaaaaaaa 3", dat, src);
        end
    endtask

    task automatic test_latency();
        int first;
        logic busy_ok, stable;
        logic [2:0] c_op; logic [1:0] c_src; logic [3:0] c_sz; logic [63:0] c_dat; logic c_den;
        first = 0; busy_ok = 1'b1; stable = 1'b1;
        @(negedge clock);
        a_opcode = 3'd0; a_size = 4'd3; a_source = 2'd1; a_address = BASE + 32'h10;
        a_mask = 8'hFF; a_data = 64'hDEADBEEFCAFEF00D; a_corrupt = 1'b0;
        a_valid4 = 1'b1;   // held high while busy: must not be accepted again
        n_checks++;
        if (a_ready4 !== 1'b1) begin
            n_errors++; $display("FAIL lat4_idle_ready: got %b want 1", a_ready4);
        end
        @(posedge clock);
        for (int k = 1; k <= 10 && first == 0; k++) begin
            @(negedge clock);
            if (a_ready4 !== 1'b0) busy_ok = 1'b0;
            if (d_valid4 === 1'b1) first = k;
        end
        n_checks++;
        if (first != 4) begin
            n_errors++; $display("FAIL lat4_first_valid: got cycle %0d want 4", first);
        end
        c_op = d_opcode4; c_src = d_source4; c_sz = d_size4; c_dat = d_data4; c_den = d_denied4;
        for (int h = 0; h < 3; h++) begin
            @(negedge clock);
            if (a_ready4 !== 1'b0) busy_ok = 1'b0;
            if (d_valid4 !== 1'b1 || d_opcode4 !== c_op || d_source4 !== c_src ||
                d_size4 !== c_sz || d_data4 !== c_dat || d_denied4 !== c_den)
                stable = 1'b0;
        end
        n_checks++;
        if (!busy_ok) begin
            n_errors++; $display("FAIL lat4_busy_ready: a_ready seen 1 while busy, want 0");
        end
        n_checks++;
        if (!stable) begin
            n_errors++; $display("FAIL lat4_stable: d bits changed while d_ready=0");
        end
        n_checks++;
        if (c_op !== 3'd0 || c_src !== 2'd1 || c_sz !== 4'd3 || c_den !== 1'b0 || c_dat !== 64'd0) begin
            n_errors++; $display("FAIL lat4_resp: op=%0d src=%0d sz=%0d den=%b data=%h want 0/1/3/0/0",
                                 c_op, c_src, c_sz, c_den, c_dat);
        end
        a_valid4 = 1'b0;
        d_ready4 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        d_ready4 = 1'b0;
        n_checks++;
        if (d_valid4 !== 1'b0 || a_ready4 !== 1'b1) begin
            n_errors++; $display("FAIL lat4_after_dfire: d_valid=%b a_ready=%b want 0 1", d_valid4, a_ready4);
        end
        n_checks++;
        if (req_count4 !== 32'd1) begin
            n_errors++; $display("FAIL lat4_req_count: got %0d want 1", req_count4);
        end
    endtask

    task automatic test_denied();
        logic [2:0]  ops  [3] = '{3'd4, 3'd4, 3'd2};
        logic [31:0] adrs [3] = '{BASE + 32'h2000, BASE + 32'h4, BASE + 32'h8};
        logic ok, st, den, cor;
        int lat;
        logic [2:0] op; logic [3:0] sz; logic [1:0] src; logic [63:0] dat;
        for (int i = 0; i < 3; i++) begin
            xfer(ops[i], 4'd3, 2'(i), adrs[i], 8'hFF, 64'h5555555555555555, 1'b0, 0,
                 ok, lat, st, op, sz, src, den, dat, cor);
            exp_req++; exp_err++;
            n_checks++;
            if (!ok || den !== 1'b1 || cor !== 1'b1 || dat !== 64'd0 || op !== 3'd1) begin
                n_errors++; $display("FAIL denied_%0d: ok=%b den=%b cor=%b data=%h op=%0d want 1 1 0 1",
                                     i, ok, den, cor, dat, op);
            end
        end
        n_checks++;
        if (err_count !== 32'(exp_err) || exp_err != 3) begin
            n_errors++; $display("FAIL denied_err_count: got %0d want 3", err_count);
        end
    endtask

    task automatic test_corrupt_put();
        logic ok, st, den, cor;
        int lat;
        logic [2:0] op; logic [3:0] sz; logic [1:0] src; logic [63:0] dat;
        xfer(3'd0, 4'd3, 2'd0, BASE + 32'd40, 8'hFF, 64'h0102030405060708, 1'b0, 0,
             ok, lat, st, op, sz, src, den, dat, cor);
        xfer(3'd0, 4'd3, 2'd1, BASE + 32'd40, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 0,
             ok, lat, st, op, sz, src, den, dat, cor);
        exp_req += 2;
        n_checks++;
        if (!ok || op !== 3'd0 || den !== 1'b0 || cor !== 1'b0) begin
            n_errors++; $display("FAIL corrupt_put_resp: op=%0d den=%b cor=%b want 0 0 0", op, den, cor);
        end
        xfer(3'd4, 4'd3, 2'd2, BASE + 32'd40, 8'h00, 64'd0, 1'b0, 0,
             ok, lat, st, op, sz, src, den, dat, cor);
        exp_req++;
        n_checks++;
        if (!ok || dat !== 64'h0102030405060708) begin
            n_errors++; $display("FAIL corrupt_put_get: data=%h want 0102030405060708", dat);
        end
    endtask

    task automatic test_random();
        logic [2:0] op_tab [12] = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd4, 3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        logic ok, st, den, cor, rcor, e_den, e_cor;
        int lat, hold, w, sel, idx;
        longint a, off;
        logic [2:0] op, rop, e_op; logic [3:0] sz, rsz; logic [1:0] src, rsrc;
        logic [63:0] dat, rdat, e_dat; logic [7:0] msk; logic [31:0] adr;
        for (int i = 0; i < 8; i++) begin
            mdl[i] = {$urandom, $urandom};
            xfer(3'd0, 4'd3, 2'd0, BASE + 32'(8 * i), 8'hFF, mdl[i], 1'b0, 0,
                 ok, lat, st, op, sz, src, den, dat, cor);
            exp_req++;
        end
        for (int t = 0; t < 300; t++) begin
            rop  = op_tab[$urandom_range(0, 11)];
            rsz  = 4'($urandom_range(0, 4));
            rsrc = 2'($urandom_range(0, 3));
            msk  = 8'($urandom);
            rdat = {$urandom, $urandom};
            rcor = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(0, 2);
            w    = $urandom_range(0, 7);
            sel  = $urandom_range(0, 9);
            off  = longint'($urandom_range(0, 7));
            if (sel <= 5 && rsz <= 3) off = (off / (64'd1 << rsz)) * (64'd1 << rsz);
            if (sel == 8)      a = longint'(BASE) + SPAN + 8 * w;
            else if (sel == 9) a = longint'(BASE) - 8 * (w + 1);
            else               a = longint'(BASE) + 8 * w + off;
            adr = 32'(a);

            e_den = !(rop == 0 || rop == 1 || rop == 4) || rsz > 3 ||
                    (a % (64'd1 << rsz)) != 0 ||
                    a < longint'(BASE) || a >= longint'(BASE) + SPAN;
            e_op  = (rop == 0 || rop == 1) ? 3'd0 : 3'd1;
            e_cor = e_den && e_op == 3'd1;
            idx   = int'((a - longint'(BASE)) / 8);
            e_dat = (!e_den && rop == 4) ? mdl[idx] : 64'd0;
            if (!e_den && rop != 4 && !rcor)
                for (int b = 0; b < 8; b++)
                    if (msk[b]) mdl[idx][8*b +: 8] = rdat[8*b +: 8];
            exp_req++;
            if (e_den) exp_err++;

            xfer(rop, rsz, rsrc, adr, msk, rdat, rcor, hold,
                 ok, lat, st, op, sz, src, den, dat, cor);
            n_checks++;
            if (!ok || lat != 1 || !st) begin
                n_errors++; $display("FAIL rand_handshake[%0d]: ok=%b lat=%0d stable=%b want 1 1 1", t, ok, lat, st);
            end
            n_checks++;
            if (op !== e_op || den !== e_den || cor !== e_cor) begin
                n_errors++; $display("FAIL rand_status[%0d]: op=%0d den=%b cor=%b want %0d %b %b (opc=%0d sz=%0d adr=%h)",
                                     t, op, den, cor, e_op, e_den, e_cor, rop, rsz, adr);
            end
            n_checks++;
            if (dat !== e_dat || src !== rsrc || sz !== rsz) begin
                n_errors++; $display("FAIL rand_data[%0d]: data=%h src=%0d sz=%0d want %h %0d %0d",
                                     t, dat, src, sz, e_dat, rsrc, rsz);
            end
        end
        n_checks++;
        if (req_count !== 32'(exp_req) || err_count !== 32'(exp_err)) begin
            n_errors++; $display("FAIL rand_counts: req=%0d err=%0d want %0d %0d",
                                 req_count, err_count, exp_req, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic stale;
        stale = 1'b0;
        @(negedge clock);
        a_opcode = 3'd4; a_size = 4'd3; a_source = 2'd3; a_address = BASE + 32'h10;
        a_mask = 8'hFF; a_corrupt = 1'b0;
        a_valid4 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_valid4 = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (d_valid4 !== 1'b0 || a_ready4 !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid_assert: d_valid=%b a_ready=%b want 0 0", d_valid4, a_ready4);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_req = 0; exp_err = 0;
        @(negedge clock);
        n_checks++;
        if (a_ready4 !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid_ready: got %b want 1", a_ready4);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (d_valid4 !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_errors++; $display("FAIL reset_mid_stale: d_valid seen 1 after reset, want 0");
        end
        n_checks++;
        if (req_count4 !== 32'd0 || req_count !== 32'(exp_req) || err_count !== 32'(exp_err)) begin
            n_errors++; $display("FAIL reset_mid_counts: req4=%0d req=%0d err=%0d want 0 0 0",
                                 req_count4, req_count, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_put_get();
        test_latency();
        test_denied();
        test_corrupt_put();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
